// File: rtl/baggage_drop_ctrl.sv
// baggage_drop_ctrl: sequenced drop controller with hot/cold check, timed actuator, cooldown, saturating drop counter and state display
module baggage_drop_ctrl #(
  parameter int T_WIDTH         = 16,
  parameter int DROP_CYCLES     = 8,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [T_WIDTH-1:0]   t_act,
  input  logic [T_WIDTH-1:0]   t_lim,
  input  logic                 drop_en,
  output logic [6:0]           seven_seg1,
  output logic [6:0]           seven_seg2,
  output logic [6:0]           seven_seg3,
  output logic [6:0]           seven_seg4,
  output logic                 drop_activated,
  output logic                 drop_done,
  output logic                 drop_abort,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [1:0]           state_o
);
  localparam int MAX_CYC = DROP_CYCLES > COOLDOWN_CYCLES ? DROP_CYCLES : COOLDOWN_CYCLES;
  localparam int PW = $clog2(MAX_CYC + 1);
  typedef enum logic [1:0] {COLD = 2'd0, HOT = 2'd1, DROP = 2'd2, RECOVER = 2'd3} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic drop_done_q, drop_done_d, drop_abort_q, drop_abort_d;
  logic hot, drop_last, rec_last;
  logic [27:0] seg;
  always_comb begin
    hot = t_act > t_lim;
    drop_last = phase_q == PW'(DROP_CYCLES - 1);
    rec_last = phase_q == PW'(COOLDOWN_CYCLES - 1);
    state_d = state_q;
    case (state_q)
      COLD:    state_d = drop_en ? (hot ? HOT : DROP) : COLD;
      HOT:     state_d = !drop_en ? COLD : (hot ? HOT : DROP);
      DROP:    state_d = hot ? HOT : (drop_last ? RECOVER : DROP);
      RECOVER: state_d = rec_last ? COLD : RECOVER;
    endcase
    phase_d = state_d != state_q ? '0 : phase_q + 1'b1;
    drop_abort_d = state_q == DROP && hot;
    drop_done_d = state_q == DROP && !hot && drop_last;
    drop_count_d = drop_done_d ? drop_count_q + CNT_WIDTH'(!(&drop_count_q)) : drop_count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLD;
      phase_q <= '0;
      drop_count_q <= '0;
      drop_done_q <= 1'b0;
      drop_abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      drop_count_q <= drop_count_d;
      drop_done_q <= drop_done_d;
      drop_abort_q <= drop_abort_d;
    end
  end
  always_comb begin
    seg = state_q == COLD ? {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110} :
          state_q == DROP ? {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011} :
          state_q == HOT  ? {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000} :
                            {4{7'b1000000}};
  end
  assign {seven_seg1, seven_seg2, seven_seg3, seven_seg4} = seg;
  assign drop_activated = state_q == DROP;
  assign drop_done = drop_done_q;
  assign drop_abort = drop_abort_q;
  assign drop_count = drop_count_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// tb_baggage_drop_ctrl: randomized and directed bench against a cycle-level behavioural model
module tb_baggage_drop_ctrl;
  localparam int TW = 16;
  localparam int D = 8;
  localparam int C = 4;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drop_en = 1'b0;
  logic [TW-1:0] t_act = '0;
  logic [TW-1:0] t_lim = '0;
  logic [6:0] seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic drop_activated, drop_done, drop_abort;
  logic [CW-1:0] drop_count;
  logic [1:0] state_o;
  int errors = 0;
  int checks = 0;
  int m_state = 0;
  int m_left = 0;
  int m_count = 0;
  bit m_done = 0;
  bit m_abort = 0;
  baggage_drop_ctrl #(.T_WIDTH(TW), .DROP_CYCLES(D), .COOLDOWN_CYCLES(C), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .t_act(t_act), .t_lim(t_lim), .drop_en(drop_en),
    .seven_seg1(seven_seg1), .seven_seg2(seven_seg2), .seven_seg3(seven_seg3), .seven_seg4(seven_seg4),
    .drop_activated(drop_activated), .drop_done(drop_done), .drop_abort(drop_abort),
    .drop_count(drop_count), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [27:0] exp_seg(input int s);
    logic [27:0] t [4];
    t[0] = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
    t[1] = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
    t[2] = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
    t[3] = {4{7'b1000000}};
    return t[s];
  endfunction
  task automatic model_step(input bit r, input bit en, input bit hot);
    m_done = 0;
    m_abort = 0;
    if (r) begin
      m_state = 0;
      m_count = 0;
    end else if (m_state == 0) begin
      if (en) begin
        m_state = hot ? 1 : 2;
        m_left = D;
      end
    end else if (m_state == 1) begin
      if (!en) m_state = 0;
      else if (!hot) begin
        m_state = 2;
        m_left = D;
      end
    end else if (m_state == 2) begin
      m_left--;
      if (hot) begin
        m_state = 1;
        m_abort = 1;
      end else if (m_left == 0) begin
        m_state = 3;
        m_left = C;
        m_done = 1;
        m_count = m_count < (1 << CW) - 1 ? m_count + 1 : m_count;
      end
    end else begin
      m_left--;
      if (m_left == 0) m_state = 0;
    end
  endtask
  task automatic tick;
    @(posedge clk);
    model_step(rst, drop_en, t_act > t_lim);
    #1;
    chk("state", 32'(state_o), 32'(m_state));
    chk("drop_activated", 32'(drop_activated), 32'(m_state == 2));
    chk("drop_done", 32'(drop_done), 32'(m_done));
    chk("drop_abort", 32'(drop_abort), 32'(m_abort));
    chk("drop_count", 32'(drop_count), 32'(m_count));
    chk("segments", 32'({seven_seg1, seven_seg2, seven_seg3, seven_seg4}), 32'(exp_seg(m_state)));
  endtask
  initial begin
    repeat (2) tick;
    rst = 0;
    repeat (3) tick;
    t_act = 100; t_lim = 100; drop_en = 1;
    tick;
    drop_en = 0;
    repeat (16) tick;
    t_act = 200; t_lim = 150; drop_en = 1;
    repeat (3) tick;
    t_act = 150;
    repeat (2) tick;
    drop_en = 0;
    repeat (14) tick;
    t_act = 200; drop_en = 1;
    repeat (2) tick;
    drop_en = 0;
    repeat (2) tick;
    t_act = 100; drop_en = 1;
    tick;
    drop_en = 0;
    repeat (2) tick;
    t_act = 200;
    repeat (2) tick;
    t_act = 100; drop_en = 1;
    tick;
    drop_en = 0;
    repeat (D - 1) tick;
    t_act = 200;
    repeat (2) tick;
    t_act = 100; drop_en = 1;
    repeat (5 * (D + C + 1) + 2) tick;
    drop_en = 0;
    repeat (14) tick;
    drop_en = 1;
    tick;
    drop_en = 0;
    repeat (4) tick;
    rst = 1;
    tick;
    rst = 0;
    repeat (2) tick;
    drop_en = 1;
    tick;
    drop_en = 0;
    repeat (D + 1) tick;
    rst = 1;
    tick;
    rst = 0;
    repeat (2) tick;
    repeat (3000) begin
      rst = $urandom_range(63) == 0;
      drop_en = $urandom_range(3) != 0;
      t_act = TW'($urandom_range(3));
      t_lim = TW'($urandom_range(3));
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
